// File: rtl/pipe_int_mul_pkg.sv
// Shared constants and types for the pipelined integer multiplier response path.
// The optional same-cycle bypass is selected with PIPEINTMUL_RESP_BYPASS_EN.
package pipe_int_mul_pkg;

   localparam int PIM_DATA_W = 64;
   localparam int PIM_DEPTH  = 4;

   // Occupancy and credit counters must hold the value DEPTH itself.
   function automatic int pim_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int PIM_CNT_W = pim_cnt_w(PIM_DEPTH);

   typedef logic [PIM_DATA_W-1:0] product_t;

endpackage

// File: rtl/pipe_int_mul_resp_fifo_mem.sv
// Response queue storage: DEPTH x DATA_W register array,
// one synchronous write port and one asynchronous read port.
module pipe_int_mul_resp_fifo_mem
   import pipe_int_mul_pkg::*;
#(
   parameter int DATA_W = PIM_DATA_W,
   parameter int DEPTH  = PIM_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Data words need no reset: the read side is qualified by occupancy.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_int_mul_resp_queue.sv
// Response queue and issue-credit tracker behind the multiplier commit point.
// Define PIPEINTMUL_RESP_BYPASS_EN for a zero-latency path when the queue is empty.
module pipe_int_mul_resp_queue
   import pipe_int_mul_pkg::*;
#(
   parameter int DATA_W = PIM_DATA_W,
   parameter int DEPTH  = PIM_DEPTH,
   parameter int CNT_W  = pim_cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue,
   output logic              issue_ok,
   input  logic              commit,
   input  logic [DATA_W-1:0] commit_data,
   output logic              resp_val,
   input  logic              resp_rdy,
   output logic [DATA_W-1:0] resp_data,
   output logic [CNT_W-1:0]  count,
   output logic              ovf_err
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic              ovf_err_q, ovf_err_d;

   logic              empty_s, full_s, bypass_s;
   logic              deq_s, deq_mem_s, enq_s, issue_acc_s;
   logic [DATA_W-1:0] rd_data_s;

   pipe_int_mul_resp_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (enq_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (commit_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data_s)
   );

   always_comb begin
      empty_s = (count_q == '0);
      full_s  = (count_q == CNT_W'(DEPTH));
`ifdef PIPEINTMUL_RESP_BYPASS_EN
      bypass_s = empty_s & commit;
`else
      bypass_s = 1'b0;
`endif
      resp_val = bypass_s | ~empty_s;
      if (bypass_s) begin
         resp_data = commit_data;
      end else if (!empty_s) begin
         resp_data = rd_data_s;
      end else begin
         resp_data = '0;
      end

      deq_s       = resp_val & resp_rdy;
      // A bypassed product that is accepted never touches storage.
      deq_mem_s   = deq_s & ~bypass_s;
      enq_s       = commit & ~(bypass_s & resp_rdy) & (~full_s | deq_mem_s);
      issue_ok    = (outstanding_q < CNT_W'(DEPTH));
      issue_acc_s = issue & issue_ok;

      count_d       = count_q + CNT_W'(enq_s) - CNT_W'(deq_mem_s);
      outstanding_d = outstanding_q + CNT_W'(issue_acc_s) - CNT_W'(deq_s);
      wr_ptr_d      = enq_s     ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
      rd_ptr_d      = deq_mem_s ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
      ovf_err_d     = ovf_err_q | (commit & full_s & ~deq_mem_s);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         ovf_err_q     <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         ovf_err_q     <= ovf_err_d;
      end
   end

   assign count   = count_q;
   assign ovf_err = ovf_err_q;

endmodule
